song_sequencer: RTL

- Playback controller sitting between the LCD/key FSM and the tone generator.
- Consumes the FSM's music/speed/mode/volume settings and walks the selected song in a synchronous note ROM, one entry per note.
- Emits the current note code and a valid strobe to the tone generator.
- Times each note from a millisecond tick scaled by the speed setting, and handles end-of-song looping or advancing.

---
 rtl/music_pkg.sv | 37 +++
 rtl/ms_tick_gen.sv | 30 +++
 rtl/song_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the song playback path: FSM states, speed codes,
// note ROM field layout and the tempo-to-unit-length helper.
package music_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_END   = 3'd4
  } state_t;

  localparam logic [1:0] SPD_SLOW    = 2'd0;
  localparam logic [1:0] SPD_NORMAL  = 2'd1;
  localparam logic [1:0] SPD_FAST    = 2'd2;
  localparam logic [1:0] SPD_FASTEST = 2'd3;

  localparam int unsigned DUR_MSB  = 9;
  localparam int unsigned DUR_LSB  = 6;
  localparam int unsigned NOTE_MSB = 5;
  localparam logic [3:0]  END_DUR  = 4'd0;
  localparam int unsigned SONG_CNT = 4;

  // Milliseconds per duration unit for a given tempo code.
  function automatic int unsigned unit_ms_f(input logic [1:0] spd, input int unsigned base_ms);
    int unsigned u;
    case (spd)
      SPD_SLOW:    u = 2 * base_ms;
      SPD_NORMAL:  u = base_ms;
      SPD_FAST:    u = base_ms - (base_ms >> 2);
      SPD_FASTEST: u = base_ms >> 1;
      default:     u = base_ms;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts enabled clocks and flags every TICK_DIV-th one.
module ms_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Prescaler count; clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_tick_c = i_en && !i_clr && (r_cnt == CNT_MAX);

endmodule

// File: rtl/song_sequencer.sv
// Song playback controller: walks a synchronous note ROM, times each note
// from a ms tick scaled by tempo, and loops or advances at end of song.
// Optional staccato gap: define SONG_SEQ_NOTE_GAP_EN.
module song_sequencer
  import music_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned BASE_MS  = 125,
  parameter int unsigned IDX_W    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       music,
  input  logic [1:0]       speed,
  input  logic             mode,
  input  logic [2:0]       volume,
  input  logic             run,
  output logic [IDX_W+1:0] rom_addr,
  input  logic [9:0]       rom_data,
  output logic [5:0]       note_code,
  output logic             note_valid,
  output logic [1:0]       cur_song,
  output logic             song_done
);

  localparam int unsigned UNIT_W = $clog2(2 * BASE_MS + 1);

  state_t            r_state, w_state_next;
  logic [1:0]        r_cur_song, r_music_d;
  logic [IDX_W-1:0]  r_idx;
  logic [5:0]        r_note_code;
  logic [3:0]        r_dur, r_dur_cnt;
  logic [UNIT_W-1:0] r_unit_ms, r_unit_cnt;
  logic              r_song_done;

  logic              w_song_chg, w_tick, w_unit_end, w_last_tick, w_gap;
  logic [3:0]        w_rom_dur;
  logic [5:0]        w_rom_note;
  logic [UNIT_W-1:0] w_unit_now;

  assign w_rom_dur   = rom_data[DUR_MSB:DUR_LSB];
  assign w_rom_note  = rom_data[NOTE_MSB:0];
  assign w_song_chg  = (music != r_music_d);
  assign w_unit_now  = UNIT_W'(unit_ms_f(speed, BASE_MS));
  assign w_unit_end  = w_tick && (r_unit_cnt == r_unit_ms - UNIT_W'(1));
  assign w_last_tick = w_unit_end && (r_dur_cnt == r_dur - 4'd1);

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    ((r_state != ST_PLAY) || w_song_chg),
    .i_en     ((r_state == ST_PLAY) && run),
    .o_tick_c (w_tick)
  );

`ifdef SONG_SEQ_NOTE_GAP_EN
  logic [UNIT_W-1:0] w_gap_ms;
  assign w_gap_ms = UNIT_W'(((32'(r_unit_ms) >> 3) > 32'd16) ? 32'd16 : (32'(r_unit_ms) >> 3));
  assign w_gap    = (w_gap_ms != '0) && (r_dur_cnt == r_dur - 4'd1) &&
                    (r_unit_cnt >= r_unit_ms - w_gap_ms);
`else
  assign w_gap = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; a song change overrides every other transition.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (run) w_state_next = ST_FETCH;
      ST_FETCH: if (run) w_state_next = ST_WAIT;
      ST_WAIT:  w_state_next = (w_rom_dur == END_DUR) ? ST_END : ST_PLAY;
      ST_PLAY:  if (w_last_tick) w_state_next = (r_idx == '1) ? ST_END : ST_FETCH;
      ST_END:   w_state_next = ST_FETCH;
      default:  w_state_next = ST_IDLE;
    endcase
    if (w_song_chg) w_state_next = ST_FETCH;
  end

  // Song/index/note registers and the unit and duration counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_music_d   <= '0;
      r_cur_song  <= '0;
      r_idx       <= '0;
      r_note_code <= '0;
      r_dur       <= '0;
      r_dur_cnt   <= '0;
      r_unit_ms   <= '0;
      r_unit_cnt  <= '0;
      r_song_done <= 1'b0;
    end else begin
      r_music_d   <= music;
      r_song_done <= (w_state_next == ST_END);
      if (w_song_chg) begin
        r_cur_song <= music;
        r_idx      <= '0;
        r_unit_cnt <= '0;
        r_dur_cnt  <= '0;
      end else begin
        case (r_state)
          ST_WAIT: begin
            if (w_rom_dur != END_DUR) begin
              r_note_code <= w_rom_note;
              r_dur       <= w_rom_dur;
              r_unit_ms   <= w_unit_now;
              r_unit_cnt  <= '0;
              r_dur_cnt   <= '0;
            end
          end
          ST_PLAY: begin
            if (w_unit_end) begin
              r_unit_cnt <= '0;
              r_unit_ms  <= w_unit_now;
              if (w_last_tick) begin
                r_dur_cnt <= '0;
                r_idx     <= r_idx + IDX_W'(1);
              end else begin
                r_dur_cnt <= r_dur_cnt + 4'd1;
              end
            end else if (w_tick) begin
              r_unit_cnt <= r_unit_cnt + UNIT_W'(1);
            end
          end
          ST_END: begin
            r_idx <= '0;
            if (mode) r_cur_song <= (r_cur_song == 2'(SONG_CNT - 1)) ? '0 : r_cur_song + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign rom_addr   = {r_cur_song, r_idx};
  assign note_code  = r_note_code;
  assign cur_song   = r_cur_song;
  assign song_done  = r_song_done;
  assign note_valid = (r_state == ST_PLAY) && run && (volume != 3'd0) && !w_gap;

endmodule
